// File: rtl/vga_bounce_pixel_gen.sv
// vga_bounce_pixel_gen: draws a wall frame and a bouncing square, with registered RGB and syncs delayed to match
module vga_bounce_pixel_gen #(
   parameter int          H_RES      = 640,
   parameter int          V_RES      = 480,
   parameter int          WALL_W     = 8,
   parameter int          BOX_SIZE   = 32,
   parameter int          STEP       = 2,
   parameter logic [11:0] BG_COLOR   = 12'h000,
   parameter logic [11:0] WALL_COLOR = 12'hFFF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        p_tick,
   input  logic        video_on,
   input  logic        hsync_in,
   input  logic        vsync_in,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        pause,
   input  logic [2:0]  sw,
   output logic        hsync,
   output logic        vsync,
   output logic [11:0] rgb
);
   localparam logic [9:0] X_LO   = 10'(WALL_W);
   localparam logic [9:0] X_HI   = 10'(H_RES - WALL_W - BOX_SIZE);
   localparam logic [9:0] Y_LO   = 10'(WALL_W);
   localparam logic [9:0] Y_HI   = 10'(V_RES - WALL_W - BOX_SIZE);
   localparam logic [9:0] X_INIT = 10'((H_RES - BOX_SIZE) / 2);
   localparam logic [9:0] Y_INIT = 10'((V_RES - BOX_SIZE) / 2);

   logic [9:0]  box_x, box_y;
   logic        dir_x, dir_y;
   logic        frame_tick, in_box, in_wall;
   logic [11:0] colour;
   logic [10:0] next_x, next_y;

   // returns {new_dir, new_pos}; dir 1 means moving toward larger coordinates
   function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir,
                                             input logic [9:0] lo, input logic [9:0] hi);
      logic [10:0] up;
      up = {1'b0, pos} + 11'(STEP);
      return dir ? ((up >= {1'b0, hi}) ? {1'b0, hi} : {1'b1, up[9:0]})
                 : ((pos <= lo + 10'(STEP)) ? {1'b1, lo} : {1'b0, pos - 10'(STEP)});
   endfunction

   assign frame_tick = p_tick && pixel_x == 10'd0 && pixel_y == 10'(V_RES);
   assign next_x     = step_axis(box_x, dir_x, X_LO, X_HI);
   assign next_y     = step_axis(box_y, dir_y, Y_LO, Y_HI);

   always_comb begin
      in_box  = {1'b0, pixel_x} >= {1'b0, box_x} && {1'b0, pixel_x} < {1'b0, box_x} + 11'(BOX_SIZE) &&
                {1'b0, pixel_y} >= {1'b0, box_y} && {1'b0, pixel_y} < {1'b0, box_y} + 11'(BOX_SIZE);
      in_wall = pixel_x < 10'(WALL_W) || pixel_x >= 10'(H_RES - WALL_W) ||
                pixel_y < 10'(WALL_W) || pixel_y >= 10'(V_RES - WALL_W);
      colour  = !video_on ? 12'h000 :
                in_box    ? {{4{sw[2]}}, {4{sw[1]}}, {4{sw[0]}}} :
                in_wall   ? WALL_COLOR : BG_COLOR;
   end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         rgb   <= 12'h000;
         hsync <= 1'b0;
         vsync <= 1'b0;
      end else if (p_tick) begin
         rgb   <= colour;
         hsync <= hsync_in;
         vsync <= vsync_in;
      end

   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         box_x <= X_INIT;
         box_y <= Y_INIT;
         dir_x <= 1'b1;
         dir_y <= 1'b1;
      end else if (frame_tick && !pause) begin
         {dir_x, box_x} <= next_x;
         {dir_y, box_y} <= next_y;
      end
endmodule
